// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle LEGv8 control sequencer; PERF_CNT_EN builds the retired counter
// All outputs are combinational decodes of state, opcode, zero and the ready inputs.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [3:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_end;

  logic w_is_add, w_is_sub, w_is_and, w_is_orr;
  logic w_is_rtype, w_is_ldur, w_is_stur, w_is_cbz, w_is_b;
  logic [3:0] w_rtype_op;

  assign w_is_add   = (opcode == 11'b10001011000);
  assign w_is_sub   = (opcode == 11'b11001011000);
  assign w_is_and   = (opcode == 11'b10001010000);
  assign w_is_orr   = (opcode == 11'b10101010000);
  assign w_is_rtype = w_is_add | w_is_sub | w_is_and | w_is_orr;
  assign w_is_ldur  = (opcode == 11'b11111000010);
  assign w_is_stur  = (opcode == 11'b11111000000);
  assign w_is_cbz   = (opcode[10:3] == 8'b10110100);
  assign w_is_b     = (opcode[10:5] == 6'b000101);

  always_comb begin
    w_rtype_op = ALU_ADD;
    if (w_is_sub)      w_rtype_op = ALU_SUB;
    else if (w_is_and) w_rtype_op = ALU_AND;
    else if (w_is_orr) w_rtype_op = ALU_ORR;
  end

  always_comb begin
    w_next     = r_state;
    w_end      = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 4'b0000;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (w_is_rtype) begin
          alu_op = w_rtype_op;
          w_next = S_WRITEBACK;
        end else if (w_is_ldur || w_is_stur) begin
          alu_op = ALU_ADD;
          w_next = S_MEMORY;
        end else if (w_is_cbz) begin
          alu_op   = ALU_PASS;
          pc_write = zero;
          pc_src   = zero;
          w_end    = 1'b1;
        end else if (w_is_b) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          w_end    = 1'b1;
        end else begin
          illegal = 1'b1;
          w_end   = 1'b1;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_stur;
        alu_op   = ALU_ADD;
        if (dmem_ready) begin
          if (w_is_ldur) w_next = S_WRITEBACK;
          else           w_end  = 1'b1;
        end
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_ldur;
        alu_op     = w_is_ldur ? ALU_ADD : w_rtype_op;
        w_end      = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // END is a transition, not a state: run is sampled here and in IDLE only
    if (w_end) w_next = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign state = r_state;

`ifdef PERF_CNT_EN
  logic [31:0] r_retired;

  // Every END except the one leaving an illegal EXECUTE retires an instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_retired <= 32'd0;
    else if (w_end && !illegal) r_retired <= r_retired + 32'd1;
  end

  assign retired_count = r_retired;
`else
  assign retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized bench for multicycle_ctrl against a per-instruction trace model
// The model expands each instruction into its expected cycle-by-cycle inputs and outputs.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [10:0] opcode;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic [3:0]  alu_op;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] retired_count;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [10:0] op;
    logic        zero;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic [3:0]  alu;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] cnt    = 0;
  logic        in_idle = 1'b1;

  // Class ids: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 B, 8 illegal
  function automatic logic is_legal(input logic [10:0] op);
    return op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 ||
           op == 11'b10101010000 || op == 11'b11111000010 || op == 11'b11111000000 ||
           op[10:3] == 8'b10110100 || op[10:5] == 6'b000101;
  endfunction

  function automatic logic [10:0] opcode_of(input int cls);
    logic [31:0] rnd;
    logic [10:0] op;
    rnd = $urandom;
    case (cls)
      0: op = 11'b10001011000;
      1: op = 11'b11001011000;
      2: op = 11'b10001010000;
      3: op = 11'b10101010000;
      4: op = 11'b11111000010;
      5: op = 11'b11111000000;
      6: op = {8'b10110100, rnd[2:0]};
      7: op = {6'b000101, rnd[4:0]};
      default: begin
        op = rnd[10:0];
        while (is_legal(op)) begin
          rnd = $urandom;
          op  = rnd[10:0];
        end
      end
    endcase
    return op;
  endfunction

  function automatic logic [3:0] alu_of(input int cls);
    case (cls)
      0: return 4'b0010;
      1: return 4'b0110;
      2: return 4'b0000;
      3: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic cyc_t new_rec(input logic [2:0] st);
    cyc_t        r;
    logic [31:0] rnd;
    rnd          = $urandom;
    r.run        = rnd[0];
    r.op         = rnd[11:1];
    r.zero       = rnd[12];
    r.ir         = rnd[13];
    r.dr         = rnd[14];
    r.st         = st;
    r.imem_req   = 1'b0;
    r.ir_write   = 1'b0;
    r.pc_write   = 1'b0;
    r.pc_src     = 1'b0;
    r.alu        = 4'b0000;
    r.dmem_req   = 1'b0;
    r.dmem_we    = 1'b0;
    r.reg_write  = 1'b0;
    r.mem_to_reg = 1'b0;
    r.illegal    = 1'b0;
    r.cnt        = cnt;
    return r;
  endfunction

  task automatic gen_idle(input int n);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r = new_rec(3'd0);
      r.run = 1'b0;
      q.push_back(r);
    end
  endtask

  task automatic gen_wake(input int n);
    cyc_t r;
    gen_idle(n);
    r = new_rec(3'd0);
    r.run = 1'b1;
    q.push_back(r);
    in_idle = 1'b0;
  endtask

  task automatic gen_instr(input int cls, input logic [10:0] op, input int fw, input int mw,
                           input logic zv, input logic re);
    cyc_t r;
    logic do_mem, do_wb;
    do_mem = (cls == 4 || cls == 5);
    do_wb  = (cls <= 4);
    for (int i = 0; i < fw; i++) begin
      r = new_rec(3'd1);
      r.ir = 1'b0;
      r.imem_req = 1'b1;
      q.push_back(r);
    end
    r = new_rec(3'd1);
    r.ir = 1'b1; r.imem_req = 1'b1; r.ir_write = 1'b1; r.pc_write = 1'b1;
    q.push_back(r);
    q.push_back(new_rec(3'd2));
    r = new_rec(3'd3);
    r.op = op; r.zero = zv;
    if (cls <= 3) r.alu = alu_of(cls);
    else if (do_mem) r.alu = 4'b0010;
    else if (cls == 6) begin
      r.alu = 4'b0111; r.pc_write = zv; r.pc_src = zv; r.run = re;
    end else if (cls == 7) begin
      r.pc_write = 1'b1; r.pc_src = 1'b1; r.run = re;
    end else begin
      r.illegal = 1'b1; r.run = re;
    end
    q.push_back(r);
    if (do_mem) begin
      for (int i = 0; i <= mw; i++) begin
        r = new_rec(3'd4);
        r.op = op; r.dr = (i == mw);
        r.dmem_req = 1'b1; r.dmem_we = (cls == 5); r.alu = 4'b0010;
        if (i == mw && cls == 5) r.run = re;
        q.push_back(r);
      end
    end
    if (do_wb) begin
      r = new_rec(3'd5);
      r.op = op; r.reg_write = 1'b1; r.mem_to_reg = (cls == 4);
      r.alu = alu_of(cls); r.run = re;
      q.push_back(r);
    end
    if (cls != 8) cnt = cnt + 32'd1;
    in_idle = !re;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef PERF_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic drive(input logic rn, input logic [10:0] op, input logic z, input logic ir,
                       input logic dr);
    @(posedge clk);
    #1;
    run = rn; opcode = op; zero = z; imem_ready = ir; dmem_ready = dr;
  endtask

  initial begin
    int   base, len;
    int   cls, fw, mw, nidle;
    logic zv, re;
    logic [31:0] rnd;
    cyc_t r;

    rst_n = 1'b0; run = 1'b1; opcode = 11'b10001011000; zero = 1'b1;
    imem_ready = 1'b1; dmem_ready = 1'b1;

    // Directed sequence with literal pins on the model itself
    gen_wake(0);
    base = q.size(); gen_instr(0, opcode_of(0), 0, 0, 1'b0, 1'b1);
    chk("model_len_add", q.size() - base, 4);
    chk("model_cnt_after_add", cnt, 1);
    base = q.size(); gen_instr(4, opcode_of(4), 0, 3, 1'b0, 1'b1);
    chk("model_len_ldur_w3", q.size() - base, 8);
    base = q.size(); gen_instr(6, opcode_of(6), 0, 0, 1'b1, 1'b1);
    chk("model_len_cbz_taken", q.size() - base, 3);
    chk("model_cbz_taken_pcsrc", {31'd0, q[base + 2].pc_src}, 1);
    base = q.size(); gen_instr(6, opcode_of(6), 0, 0, 1'b0, 1'b1);
    chk("model_len_cbz_not", q.size() - base, 3);
    base = q.size(); gen_instr(5, opcode_of(5), 0, 0, 1'b0, 1'b1);
    chk("model_len_stur", q.size() - base, 4);
    gen_instr(7, opcode_of(7), 1, 0, 1'b0, 1'b1);
    base = q.size(); gen_instr(8, 11'b00000000000, 0, 0, 1'b0, 1'b0);
    chk("model_len_illegal", q.size() - base, 3);
    chk("model_cnt_directed", cnt, 6);
    gen_idle(5);

    for (int k = 0; k < 60; k++) begin
      rnd = $urandom;
      cls = rnd[3:0] % 9;
      fw  = (rnd[5:4] == 2'd0) ? int'(rnd[7:6]) : 0;
      mw  = (rnd[9:8] == 2'd0) ? int'(rnd[11:10]) : 0;
      zv  = rnd[12];
      re  = (k == 59) ? 1'b0 : (rnd[15:13] != 3'd0);
      nidle = int'(rnd[17:16]);
      if (in_idle) gen_wake(nidle);
      gen_instr(cls, opcode_of(cls), fw, mw, zv, re);
    end
    gen_idle(2);

    // Reset: held low with run = 1, everything idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_state", {29'd0, state}, 0);
      chk("rst_outputs", {imem_req, ir_write, pc_write, pc_src, alu_op, dmem_req, dmem_we,
                          reg_write, mem_to_reg, illegal}, 0);
      chk("rst_count", retired_count, 0);
    end

    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run = r.run; opcode = r.op; zero = r.zero; imem_ready = r.ir; dmem_ready = r.dr;
      @(negedge clk);
      chk("state", {29'd0, state}, {29'd0, r.st});
      chk("imem_req", {31'd0, imem_req}, {31'd0, r.imem_req});
      chk("ir_write", {31'd0, ir_write}, {31'd0, r.ir_write});
      chk("pc_write", {31'd0, pc_write}, {31'd0, r.pc_write});
      chk("pc_src", {31'd0, pc_src}, {31'd0, r.pc_src});
      chk("alu_op", {28'd0, alu_op}, {28'd0, r.alu});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, r.dmem_req});
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, r.dmem_we});
      chk("reg_write", {31'd0, reg_write}, {31'd0, r.reg_write});
      chk("mem_to_reg", {31'd0, mem_to_reg}, {31'd0, r.mem_to_reg});
      chk("illegal", {31'd0, illegal}, {31'd0, r.illegal});
      chk("retired_count", retired_count, exp_cnt(r.cnt));
    end

    // Reset while a load waits in MEMORY
    drive(1'b1, 11'b11111000010, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 11'b11111000010, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 11'b11111000010, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 11'b11111000010, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 11'b11111000010, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midmem_state_before", {29'd0, state}, 4);
    chk("midmem_req_before", {31'd0, dmem_req}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midmem_req_after_rst", {31'd0, dmem_req}, 0);
    chk("midmem_state_after_rst", {29'd0, state}, 0);
    chk("midmem_count_after_rst", retired_count, 0);
    run = 1'b0;
    dmem_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 11'b11111000010, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("late_ready_state", {29'd0, state}, 0);
      chk("late_ready_dmem_req", {31'd0, dmem_req}, 0);
      chk("late_ready_reg_write", {31'd0, reg_write}, 0);
      chk("late_ready_count", retired_count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
